sound_line_decoder: RTL and testbench
=====================================

Name: sound_line_decoder

Overview:
- Receive-side decoder for the scanline-gated 1-bit sound stream produced by the sound generator.
- Samples `sound` every pixel clock and measures, per scanline, the high-pulse width. From the run pattern of active and inactive lines it recovers the square-wave half-period and the per-note peak envelope width.
- Sits beside the sound generator in the VGA pipeline. Used for on-screen audio visualisation and as a self-check monitor in simulation.

Parameters:
- H_TOTAL, 800, pixel clocks per scanline (x counts 0..H_TOTAL-1)
- V_TOTAL, 525, scanlines per frame (y counts 0..V_TOTAL-1)
- SILENCE_LINES, 64, consecutive inactive lines that declare silence

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- x  input  10  current horizontal pixel position
- y  input  10  current vertical line position
- sound  input  1  1-bit sound stream under decode
- line_width  output  10  count of high samples in the last completed line
- line_valid  output  1  one-cycle strobe: line_width updated
- half_period  output  8  length in lines of the last completed high or low run, saturating at 255
- peak_width  output  10  maximum line_width seen during the last completed high run
- period_valid  output  1  one-cycle strobe: half_period updated (peak_width too if a high run ended)
- silent  output  1  high while in SILENT state
- active_lines  output  10  number of lines with line_width != 0 in the last completed frame
- frame_valid  output  1  one-cycle strobe: active_lines updated

Behaviour:

Reset (asynchronous, rst_n=0):
- All outputs and internal counters go to 0, except `silent`, which goes to 1.
- FSM enters SILENT.

Line accumulator (10-bit acc):
- Each cycle with x < H_TOTAL-1: acc <= acc + sound.
- At x == H_TOTAL-1: line_width <= acc + sound; acc <= 0; line_valid <= 1; last_line <= (y == V_TOTAL-1). line_valid is 0 on every other cycle.
- Cycles with x >= H_TOTAL are ignored entirely (no accumulation, no end-of-line).
- Latency: line_valid is high exactly one cycle after the x == H_TOTAL-1 sample.

Line classification:
- On line_valid, the line is active iff line_width != 0.

Run FSM (advances only on cycles where line_valid = 1; 8-bit run counter, saturating at 255):
- SILENT:
  - active line -> HIGH_RUN, run = 1, peak = line_width, silent <= 0.
  - inactive line -> stay; no report.
- HIGH_RUN:
  - active line -> run++, peak = max(peak, line_width).
  - inactive line -> half_period <= run, peak_width <= peak, period_valid <= 1; then -> LOW_RUN, run = 1.
- LOW_RUN:
  - active line -> half_period <= run, period_valid <= 1 (peak_width unchanged); then -> HIGH_RUN, run = 1, peak = line_width.
  - inactive line -> run++. If the new run == SILENCE_LINES -> SILENT, silent <= 1, no report.

FSM timing:
- period_valid is high the cycle after the consuming line_valid, i.e. 2 cycles after the last sample of the edge line. It is 0 otherwise.

Frame counter (10-bit, counts active lines on line_valid):
- On a line_valid with last_line = 1: active_lines <= count including that line; count <= 0; frame_valid <= 1, in the same cycle as any period_valid arising from that line.

Boundary conditions:
- Run saturation: a run reaching 255 holds at 255 and reports 255.
- Width range: a line of all-high samples gives line_width = 800 (fits in 10 bits).
- Partial line after reset: a line partially sampled after reset release is decoded as a normal line with a short count. No special handling.
- Reset mid-run: reset mid-run discards the run without reporting.

Test Plan:
- Reset: hold rst_n=0 mid-line, release -> all outputs 0, silent=1. First full line of sound=0 -> line_valid pulse, line_width=0, silent stays 1.
- Width measure: sound=1 for x in 256..511 on one line -> line_width=256, line_valid high one cycle after x=799.
- Square wave: alternating 30 active lines (width 248) and 30 inactive lines. After the first high run -> half_period=30, peak_width=248. Every subsequent edge -> period_valid with half_period=30.
- Envelope peak: high run with per-line widths 248, 184, 120, 56 (4 lines) -> half_period=4, peak_width=248 at the high-to-low edge.
- Silence: after a high run, 64 inactive lines -> one period_valid for the high run, none for the low run. silent=1 on the cycle after the 64th line's line_valid.
- Frame count: 100 active lines within a 525-line frame -> at the end of y=524, frame_valid=1, active_lines=100. The next frame starts its count at 0.

Source files
------------

// File: rtl/sound_line_decoder.sv
// Receive-side decoder for the scanline-gated 1-bit sound stream: per-line pulse
// width, square-wave half-period / envelope peak recovery, and per-frame activity count.
module sound_line_decoder #(
    parameter int H_TOTAL       = 800,
    parameter int V_TOTAL       = 525,
    parameter int SILENCE_LINES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       sound,
    output logic [9:0] line_width,
    output logic       line_valid,
    output logic [7:0] half_period,
    output logic [9:0] peak_width,
    output logic       period_valid,
    output logic       silent,
    output logic [9:0] active_lines,
    output logic       frame_valid
);

    typedef enum logic [1:0] {SILENT, HIGH_RUN, LOW_RUN} state_t;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [7:0] SIL_RUN  = 8'(SILENCE_LINES);

    logic [9:0] acc;
    logic       last_line;
    logic       line_active;

    // Line accumulator; x beyond the visible+blank range is ignored entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            line_width <= '0;
            line_valid <= 1'b0;
            last_line  <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            if (x == X_LAST) begin
                line_width <= acc + {9'd0, sound};
                acc        <= '0;
                line_valid <= 1'b1;
                last_line  <= (y == Y_LAST);
            end else if (x < X_LAST) begin
                acc <= acc + {9'd0, sound};
            end
        end
    end

    assign line_active = (line_width != 10'd0);

    state_t     state_q, state_d;
    logic [7:0] run_q, run_d, run_inc;
    logic [9:0] peak_q, peak_d;
    logic [7:0] half_d;
    logic [9:0] pw_d;
    logic       pv_d;

    assign run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        peak_d  = peak_q;
        half_d  = half_period;
        pw_d    = peak_width;
        pv_d    = 1'b0;
        if (line_valid) begin
            case (state_q)
                SILENT: begin
                    if (line_active) begin
                        state_d = HIGH_RUN;
                        run_d   = 8'd1;
                        peak_d  = line_width;
                    end
                end
                HIGH_RUN: begin
                    if (line_active) begin
                        run_d  = run_inc;
                        peak_d = (line_width > peak_q) ? line_width : peak_q;
                    end else begin
                        half_d  = run_q;
                        pw_d    = peak_q;
                        pv_d    = 1'b1;
                        state_d = LOW_RUN;
                        run_d   = 8'd1;
                    end
                end
                LOW_RUN: begin
                    if (line_active) begin
                        half_d  = run_q;
                        pv_d    = 1'b1;
                        state_d = HIGH_RUN;
                        run_d   = 8'd1;
                        peak_d  = line_width;
                    end else begin
                        run_d = run_inc;
                        // A long enough low run is silence, not half a period: no report.
                        if (run_inc == SIL_RUN) state_d = SILENT;
                    end
                end
                default: state_d = SILENT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SILENT;
            run_q        <= '0;
            peak_q       <= '0;
            half_period  <= '0;
            peak_width   <= '0;
            period_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            peak_q       <= peak_d;
            half_period  <= half_d;
            peak_width   <= pw_d;
            period_valid <= pv_d;
        end
    end

    assign silent = (state_q == SILENT);

    logic [9:0] frame_cnt;
    logic [9:0] frame_cnt_inc;

    assign frame_cnt_inc = frame_cnt + {9'd0, line_active};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            active_lines <= '0;
            frame_valid  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (line_valid) begin
                if (last_line) begin
                    active_lines <= frame_cnt_inc;
                    frame_cnt    <= '0;
                    frame_valid  <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_line_decoder.sv
// Bench for sound_line_decoder: line-level behavioural model with cycle-stamped
// expected events, a per-cycle compare process, and literal spot checks.
module tb_sound_line_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       sound = 1'b0;
    logic [9:0] line_width;
    logic       line_valid;
    logic [7:0] half_period;
    logic [9:0] peak_width;
    logic       period_valid;
    logic       silent;
    logic [9:0] active_lines;
    logic       frame_valid;

    sound_line_decoder dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .sound(sound),
        .line_width(line_width), .line_valid(line_valid),
        .half_period(half_period), .peak_width(peak_width),
        .period_valid(period_valid), .silent(silent),
        .active_lines(active_lines), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line-level model: what each completed line must produce, stamped with the
    // cycle at which it must appear on the outputs.
    int macc = 0;
    bit m_sil = 1'b1;
    bit m_high = 1'b0;
    int m_run = 0;
    int m_peak = 0;
    int m_fcnt = 0;
    int lv_w[int];
    int pv_h[int];
    int pv_p[int];
    int fv_a[int];
    int sil_at[int];

    function automatic void model_reset();
        macc = 0; m_sil = 1'b1; m_high = 1'b0; m_run = 0; m_peak = 0; m_fcnt = 0;
        lv_w.delete(); pv_h.delete(); pv_p.delete(); fv_a.delete(); sil_at.delete();
    endfunction

    function automatic void model_line(int w, bit last, int c);
        bit act;
        act = (w != 0);
        lv_w[c+1] = w;
        m_fcnt += act ? 1 : 0;
        if (last) begin
            fv_a[c+2] = m_fcnt;
            m_fcnt = 0;
        end
        if (m_sil) begin
            if (act) begin
                m_sil = 1'b0; m_high = 1'b1; m_run = 1; m_peak = w; sil_at[c+2] = 0;
            end
        end else if (m_high) begin
            if (act) begin
                m_run = (m_run >= 255) ? 255 : m_run + 1;
                if (w > m_peak) m_peak = w;
            end else begin
                pv_h[c+2] = m_run; pv_p[c+2] = m_peak;
                m_high = 1'b0; m_run = 1;
            end
        end else begin
            if (act) begin
                pv_h[c+2] = m_run; pv_p[c+2] = -1;
                m_high = 1'b1; m_run = 1; m_peak = w;
            end else begin
                m_run = (m_run >= 255) ? 255 : m_run + 1;
                if (m_run == 64) begin
                    m_sil = 1'b1; sil_at[c+2] = 1;
                end
            end
        end
    endfunction

    // Compare process: shadow registers follow the model's scheduled events.
    int e_lw = 0, e_half = 0, e_peak = 0, e_act = 0, e_sil = 1;
    always @(negedge clk) begin
        int e_lv, e_pv, e_fv;
        if (!rst_n) begin
            e_lw = 0; e_half = 0; e_peak = 0; e_act = 0; e_sil = 1;
            e_lv = 0; e_pv = 0; e_fv = 0;
        end else begin
            e_lv = lv_w.exists(cyc) ? 1 : 0;
            e_pv = pv_h.exists(cyc) ? 1 : 0;
            e_fv = fv_a.exists(cyc) ? 1 : 0;
            if (e_lv != 0) e_lw = lv_w[cyc];
            if (e_pv != 0) begin
                e_half = pv_h[cyc];
                if (pv_p[cyc] >= 0) e_peak = pv_p[cyc];
            end
            if (e_fv != 0) e_act = fv_a[cyc];
            if (sil_at.exists(cyc)) e_sil = sil_at[cyc];
        end
        chk("line_valid", int'(line_valid), e_lv);
        chk("line_width", int'(line_width), e_lw);
        chk("period_valid", int'(period_valid), e_pv);
        chk("half_period", int'(half_period), e_half);
        chk("peak_width", int'(peak_width), e_peak);
        chk("frame_valid", int'(frame_valid), e_fv);
        chk("active_lines", int'(active_lines), e_act);
        chk("silent", int'(silent), e_sil);
    end

    bit rst_req = 1'b0;

    task automatic drive(int xv, int yv, bit s);
        @(posedge clk);
        #1;
        rst_n = rst_req;
        x = 10'(xv); y = 10'(yv); sound = s;
        if (!rst_n) model_reset();
        else if (xv < 799) macc += s ? 1 : 0;
        else if (xv == 799) begin
            model_line(macc + (s ? 1 : 0), yv == 524, cyc);
            macc = 0;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(900, 0, 1'b1);
    endtask

    // Compressed line: w high samples, then the end-of-line sample.
    task automatic cline(int yv, int w);
        for (int i = 0; i < w; i++) drive(i, yv, 1'b1);
        drive(799, yv, 1'b0);
    endtask

    task automatic rline(int yv, int lo, int hi);
        for (int xx = 0; xx < 800; xx++) drive(xx, yv, (xx >= lo) && (xx < hi));
    endtask

    initial begin
        // Reset held mid-line with sound high; release and finish the line silent.
        rst_req = 1'b0;
        for (int xx = 300; xx < 400; xx++) drive(xx, 0, 1'b1);
        chk("lit_rst_silent", int'(silent), 1);
        chk("lit_rst_width", int'(line_width), 0);
        rst_req = 1'b1;
        for (int xx = 400; xx < 800; xx++) drive(xx, 0, 1'b0);
        idle(1);
        chk("lit_first_lv", int'(line_valid), 1);
        chk("lit_first_width", int'(line_width), 0);
        chk("lit_first_silent", int'(silent), 1);

        rline(1, 256, 512);
        idle(1);
        chk("lit_w256_lv", int'(line_valid), 1);
        chk("lit_w256", int'(line_width), 256);
        rline(2, 0, 800);
        idle(1);
        chk("lit_w800", int'(line_width), 800);

        // High run of 2 then silence
        for (int i = 0; i < 64; i++) cline(3, 0);
        idle(2);
        chk("lit_sil_half", int'(half_period), 2);
        chk("lit_sil_peak", int'(peak_width), 800);
        chk("lit_sil_silent", int'(silent), 1);

        // Square wave, 30 on / 30 off
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 30; i++) cline(4, 248);
            for (int i = 0; i < 30; i++) cline(4, 0);
            if (r == 0) begin
                chk("lit_sq_half", int'(half_period), 30);
                chk("lit_sq_peak", int'(peak_width), 248);
            end
        end
        for (int i = 0; i < 30; i++) cline(4, 248);
        for (int i = 0; i < 30; i++) cline(4, 0);

        // Envelope
        cline(5, 248); cline(5, 184); cline(5, 120); cline(5, 56);
        cline(5, 0);
        idle(2);
        chk("lit_env_pv", int'(period_valid), 1);
        chk("lit_env_half", int'(half_period), 4);
        chk("lit_env_peak", int'(peak_width), 248);

        // Reset mid high run: nothing reported afterwards
        for (int i = 0; i < 3; i++) cline(6, 5);
        rst_req = 1'b0;
        idle(3);
        rst_req = 1'b1;
        for (int i = 0; i < 3; i++) cline(6, 0);
        idle(2);
        chk("lit_midrst_silent", int'(silent), 1);
        chk("lit_midrst_half", int'(half_period), 0);

        // Run saturation
        for (int i = 0; i < 260; i++) cline(7, 1);
        cline(7, 0);
        idle(2);
        chk("lit_sat_half", int'(half_period), 255);
        chk("lit_sat_peak", int'(peak_width), 1);

        // Frame count: flush the partial frame first
        cline(524, 0);
        for (int yy = 0; yy < 525; yy++) cline(yy, (yy < 100) ? 1 : 0);
        idle(2);
        chk("lit_frame_fv", int'(frame_valid), 1);
        chk("lit_frame_act", int'(active_lines), 100);
        cline(0, 3);
        cline(524, 0);
        idle(2);
        chk("lit_frame2_act", int'(active_lines), 1);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
